// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: each accepted beat lands in the
// one-entry holding register of the lane named by in_sel, with per-lane debug counters.
module demux1to4_stream #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   input  logic [1:0]          in_sel,
   output logic [3:0]          out_valid,
   input  logic [3:0]          out_ready,
   output logic [4*WIDTH-1:0]  out_data,
   input  logic                cnt_clr,
   output logic [4*CNTW-1:0]   out_cnt
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [3:0]       full;
   logic [3:0]       load;
   logic [3:0]       fire;
   logic [WIDTH-1:0] data_q [4];
   logic [CNTW-1:0]  cnt_q  [4];

   // A lane can take a new beat when empty or when its held beat leaves this cycle.
   assign in_ready = !full[in_sel] || out_ready[in_sel];
   assign fire     = full & out_ready;

   always_comb begin
      load = '0;
      if (in_valid && in_ready) begin
         load[in_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load[i]) begin
               full[i]   <= 1'b1;
               data_q[i] <= in_data;
            end else if (fire[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   // Clear has priority over a same-cycle delivery; counts saturate rather than wrap.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (fire[i] && (cnt_q[i] != CNT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign out_valid = full;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign out_data[g*WIDTH +: WIDTH] = data_q[g];
      assign out_cnt[g*CNTW +: CNTW]    = cnt_q[g];
   end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Bench for demux1to4_stream: vector table, directed corner sequences and
// randomized traffic against a per-lane queue model.
module tb_demux1to4_stream;

   localparam int W = 8;
   localparam int C = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [1:0]     in_sel;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready;
   logic [4*W-1:0] out_data;
   logic           cnt_clr;
   logic [4*C-1:0] out_cnt;

   always #5 clk = ~clk;

   demux1to4_stream #(.WIDTH(W), .CNTW(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .out_cnt   (out_cnt)
   );

   int total  = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
   endtask

   // Reference model: each lane is a FIFO of capacity one, plus the last
   // payload written (what the lane register shows) and a saturating count.
   logic [W-1:0] mq [4][$];
   logic [W-1:0] mlast [4];
   int           mcnt [4];

   function automatic logic model_ready(input logic [1:0] s);
      return (mq[s].size() == 0) || out_ready[s];
   endfunction

   task automatic model_step();
      logic acc;
      logic [W-1:0] junk;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mlast[i] = '0;
            mcnt[i]  = 0;
         end
      end else begin
         acc = in_valid && model_ready(in_sel);
         for (int i = 0; i < 4; i++) begin
            logic f;
            f = (mq[i].size() > 0) && out_ready[i];
            if (f) junk = mq[i].pop_front();
            if (cnt_clr) mcnt[i] = 0;
            else if (f && mcnt[i] < (1 << C) - 1) mcnt[i]++;
         end
         if (acc) begin
            mq[in_sel].push_back(in_data);
            mlast[in_sel] = in_data;
         end
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] r, input logic c = 1'b0, input logic rs = 1'b0);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      cnt_clr   = c;
      rst       = rs;
   endtask

   // One clock: check in_ready before the edge, advance the model, check state after.
   task automatic tick(input string tag);
      logic [3:0]     ev;
      logic [4*W-1:0] ed;
      logic [4*C-1:0] ec;
      #1;
      chk({tag, "_in_ready"}, in_ready, model_ready(in_sel));
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         ev[i]         = mq[i].size() > 0;
         ed[i*W +: W]  = mlast[i];
         ec[i*C +: C]  = C'(mcnt[i]);
      end
      chk({tag, "_out_valid"}, out_valid, ev);
      chk({tag, "_out_data"},  out_data,  ed);
      chk({tag, "_out_cnt"},   out_cnt,   ec);
   endtask

   typedef struct {
      logic           v;
      logic [1:0]     s;
      logic [7:0]     d;
      logic [3:0]     r;
      logic           exp_rdy;
      logic [3:0]     exp_v;
      logic [31:0]    exp_d;
      logic [15:0]    exp_c;
   } vec_t;

   vec_t tbl [5];

   initial begin
      tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 16'h0000};
      tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 16'h0001};
      tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 16'h0011};
      tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 16'h0111};
      tbl[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 16'h1111};

      // Reset then idle
      drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 1'b1);
      tick("rst0");
      tick("rst1");
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      tick("idle");
      chk("reset_valid", out_valid, 4'b0000);
      chk("reset_data",  out_data,  32'h0);
      chk("reset_cnt",   out_cnt,   16'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         chk("reset_in_ready", in_ready, 1'b1);
      end

      // Routing sweep
      for (int k = 0; k < 5; k++) begin
         drive(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].r);
         #1;
         chk("tbl_rdy", in_ready, tbl[k].exp_rdy);
         tick("tbl");
         chk("tbl_valid", out_valid, tbl[k].exp_v);
         chk("tbl_data",  out_data,  tbl[k].exp_d);
         chk("tbl_cnt",   out_cnt,   tbl[k].exp_c);
      end

      // Backpressure isolation
      drive(1'b1, 2'd2, 8'h55, 4'b1011);
      tick("bp_load");
      chk("bp_lane2_valid", out_valid[2], 1'b1);
      chk("bp_lane2_data",  out_data[23:16], 8'h55);
      drive(1'b1, 2'd2, 8'h66, 4'b1011);
      #1;
      chk("bp_blocked", in_ready, 1'b0);
      tick("bp_stall0");
      tick("bp_stall1");
      chk("bp_hold", out_data[23:16], 8'h55);
      drive(1'b1, 2'd0, 8'h77, 4'b1011);
      #1;
      chk("bp_other_lane_ready", in_ready, 1'b1);
      tick("bp_lane0");
      chk("bp_lane0_valid", out_valid[0], 1'b1);
      chk("bp_lane0_data",  out_data[7:0], 8'h77);
      chk("bp_lane2_still", out_data[23:16], 8'h55);
      drive(1'b1, 2'd2, 8'h66, 4'b1111);
      #1;
      chk("bp_release_ready", in_ready, 1'b1);
      tick("bp_release");
      chk("bp_66_valid", out_valid[2], 1'b1);
      chk("bp_66_data",  out_data[23:16], 8'h66);
      drive(1'b0, 2'd0, 8'h00, 4'b1111);
      tick("bp_drain");

      // Pass-through throughput on lane 1
      drive(1'b1, 2'd1, 8'h0F, 4'b0000);
      tick("pt_fill");
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 2'd1, 8'(8'h10 + k), 4'b1111, k == 0);
         #1;
         chk("pt_in_ready", in_ready, 1'b1);
         tick("pt");
         chk("pt_valid", out_valid[1], 1'b1);
         chk("pt_data",  out_data[15:8], 8'(8'h10 + k));
      end
      drive(1'b0, 2'd0, 8'h00, 4'b1111);
      tick("pt_drain");
      chk("pt_cnt1", out_cnt[7:4], 4'd8);

      // Reset mid-operation
      drive(1'b1, 2'd0, 8'hC0, 4'b0000);
      tick("rm_l0");
      drive(1'b1, 2'd3, 8'hC3, 4'b0000);
      tick("rm_l3");
      chk("rm_full", out_valid, 4'b1001);
      drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b1);
      tick("rm_rst");
      chk("rm_valid0", out_valid, 4'b0000);
      chk("rm_data0",  out_data,  32'h0);
      drive(1'b0, 2'd0, 8'h00, 4'b1111);
      tick("rm_after0");
      tick("rm_after1");
      chk("rm_never", out_valid, 4'b0000);

      // Counter saturate then clear against a same-cycle fire
      drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
      tick("sat_clr");
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 2'd0, 8'(k), 4'b1111);
         tick("sat");
      end
      drive(1'b0, 2'd0, 8'h00, 4'b1111);
      tick("sat_drain");
      chk("sat_cnt0", out_cnt[3:0], 4'd15);
      drive(1'b1, 2'd0, 8'hEE, 4'b0000);
      tick("sat_load");
      drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
      tick("sat_fire_clr");
      chk("clr_wins", out_cnt[3:0], 4'd0);
      chk("clr_fired", out_valid[0], 1'b0);

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
               4'($urandom), $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
         tick("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
